// File: rtl/vga_timing_if.sv
// vga_timing_if: raster coordinates, DAC strobes and frame timing produced by vga_timing_gen
interface vga_timing_if #(
  parameter int unsigned VGA_WIDTH = 12,
  parameter int unsigned FCNT_WIDTH = 16
);
  logic [VGA_WIDTH-1:0] hdata;
  logic [VGA_WIDTH-1:0] vdata;
  logic hsync;
  logic vsync;
  logic data_enable;
  logic line_start;
  logic frame_start;
  logic [FCNT_WIDTH-1:0] frame_count;
  modport master (output hdata, vdata, hsync, vsync, data_enable, line_start, frame_start, frame_count);
  modport slave (input hdata, vdata, hsync, vsync, data_enable, line_start, frame_start, frame_count);
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, pipeline-aligned sync/DE strobes, line/frame pulses and frame counter
module vga_timing_gen #(
  parameter int unsigned VGA_WIDTH = 12,
  parameter int unsigned HSIZE = 800,
  parameter int unsigned HFP = 856,
  parameter int unsigned HSP = 976,
  parameter int unsigned HMAX = 1040,
  parameter int unsigned VSIZE = 600,
  parameter int unsigned VFP = 637,
  parameter int unsigned VSP = 643,
  parameter int unsigned VMAX = 666,
  parameter bit HSPP = 1'b1,
  parameter bit VSPP = 1'b1,
  parameter int unsigned PIPE_DELAY = 1,
  parameter int unsigned FCNT_WIDTH = 16
) (
  input logic clk,
  input logic reset,
  vga_timing_if.master vga
);
  localparam logic [VGA_WIDTH-1:0] H_LAST = VGA_WIDTH'(HMAX - 1);
  localparam logic [VGA_WIDTH-1:0] V_LAST = VGA_WIDTH'(VMAX - 1);
  localparam logic [2:0] IDLE = {~HSPP, ~VSPP, 1'b0};
  if (!(HSIZE < HFP && HFP < HSP && HSP <= HMAX && VSIZE < VFP && VFP < VSP && VSP <= VMAX &&
        64'(HMAX) <= (64'd1 << VGA_WIDTH) && 64'(VMAX) <= (64'd1 << VGA_WIDTH) && PIPE_DELAY <= 4)) begin : g_bad_params
    $error("vga_timing_gen: inconsistent timing parameters");
  end
  logic [VGA_WIDTH-1:0] h, v;
  logic [FCNT_WIDTH-1:0] fc;
  logic h_end, v_end, ls;
  logic [2:0] raw, src, dly;
  assign h_end = h == H_LAST;
  assign v_end = v == V_LAST;
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
      fc <= '0;
    end else begin
      h <= h_end ? '0 : h + 1'b1;
      if (h_end) v <= v_end ? '0 : v + 1'b1;
      if (h_end && v_end) fc <= fc + 1'b1;
    end
  end
  always_comb begin
    raw[2] = (32'(h) >= HFP && 32'(h) < HSP) ? HSPP : ~HSPP;
    raw[1] = (32'(v) >= VFP && 32'(v) < VSP) ? VSPP : ~VSPP;
    raw[0] = 32'(h) < HSIZE && 32'(v) < VSIZE;
    src = reset ? IDLE : raw;
  end
  if (PIPE_DELAY == 0) begin : g_nodly
    assign dly = src;
  end else begin : g_pipe
    logic [2:0] sr [PIPE_DELAY];
    always_ff @(posedge clk) begin
      sr[0] <= src;
      for (int i = 1; i < PIPE_DELAY; i++) sr[i] <= reset ? IDLE : sr[i-1];
    end
    assign dly = sr[PIPE_DELAY-1];
  end
  assign ls = !reset && h == '0;
  assign vga.hdata = h;
  assign vga.vdata = v;
  assign vga.frame_count = fc;
  assign vga.line_start = ls;
  assign vga.frame_start = ls && v == '0;
  assign {vga.hsync, vga.vsync, vga.data_enable} = dly;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard check of vga_timing_gen on a shrunken raster with a 2-bit frame counter
module tb_vga_timing_gen;
  localparam int W = 8;
  localparam int HSIZE = 8, HFP = 10, HSP = 12, HMAX = 14;
  localparam int VSIZE = 4, VFP = 5, VSP = 6, VMAX = 7;
  localparam bit HSPP = 1'b1, VSPP = 1'b0;
  localparam int FCW = 2;
  localparam int FRAME = HMAX * VMAX;
  typedef struct {
    logic [31:0] h, v, fc;
    bit hs, vs, de, ls, fs;
  } exp_t;
  logic clk = 0;
  logic reset = 1;
  int tests = 0, fails = 0;
  int m_h, m_v, m_fc;
  bit p_hs, p_vs, p_de;
  int hs_cnt, vs_cnt, de_cnt;
  exp_t q[$];
  vga_timing_if #(.VGA_WIDTH(W), .FCNT_WIDTH(FCW)) vif();
  vga_timing_gen #(
    .VGA_WIDTH(W), .HSIZE(HSIZE), .HFP(HFP), .HSP(HSP), .HMAX(HMAX),
    .VSIZE(VSIZE), .VFP(VFP), .VSP(VSP), .VMAX(VMAX),
    .HSPP(HSPP), .VSPP(VSPP), .PIPE_DELAY(1), .FCNT_WIDTH(FCW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vga(vif)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, o, e);
    end
  endtask
  task automatic cyc(input logic r);
    exp_t e, g;
    bit rh, rv, rd;
    reset = r;
    #1;
    e.h = m_h;
    e.v = m_v;
    e.fc = m_fc;
    e.ls = !r && m_h == 0;
    e.fs = !r && m_h == 0 && m_v == 0;
    e.hs = p_hs;
    e.vs = p_vs;
    e.de = p_de;
    q.push_back(e);
    g = q.pop_front();
    chk("hdata", 32'(vif.hdata), g.h);
    chk("vdata", 32'(vif.vdata), g.v);
    chk("frame_count", 32'(vif.frame_count), g.fc);
    chk("hsync", 32'(vif.hsync), 32'(g.hs));
    chk("vsync", 32'(vif.vsync), 32'(g.vs));
    chk("data_enable", 32'(vif.data_enable), 32'(g.de));
    chk("line_start", 32'(vif.line_start), 32'(g.ls));
    chk("frame_start", 32'(vif.frame_start), 32'(g.fs));
    if (vif.hsync === HSPP) hs_cnt++;
    if (vif.vsync === VSPP) vs_cnt++;
    if (vif.data_enable === 1'b1) de_cnt++;
    rh = (m_h >= HFP && m_h < HSP) ? HSPP : !HSPP;
    rv = (m_v >= VFP && m_v < VSP) ? VSPP : !VSPP;
    rd = m_h < HSIZE && m_v < VSIZE;
    @(posedge clk);
    #1;
    if (r) begin
      m_h = 0; m_v = 0; m_fc = 0;
      p_hs = !HSPP; p_vs = !VSPP; p_de = 0;
    end else begin
      p_hs = rh; p_vs = rv; p_de = rd;
      if (m_h == HMAX - 1) begin
        m_h = 0;
        if (m_v == VMAX - 1) begin
          m_v = 0;
          m_fc = (m_fc + 1) % (1 << FCW);
        end else m_v++;
      end else m_h++;
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    m_h = 0; m_v = 0; m_fc = 0;
    p_hs = !HSPP; p_vs = !VSPP; p_de = 0;
    repeat (3) cyc(1);
    hs_cnt = 0; vs_cnt = 0; de_cnt = 0;
    repeat (FRAME) cyc(0);
    chk("hsync_cycles_per_frame", 32'(hs_cnt), 32'(VMAX * (HSP - HFP)));
    chk("vsync_cycles_per_frame", 32'(vs_cnt), 32'((VSP - VFP) * HMAX));
    chk("de_cycles_per_frame", 32'(de_cnt), 32'(HSIZE * VSIZE));
    chk("frame_count_after_1", 32'(vif.frame_count), 32'd1);
    repeat (3 * FRAME) cyc(0);
    chk("frame_count_wrap", 32'(vif.frame_count), 32'd0);
    repeat (3 * HMAX + 5) cyc(0);
    chk("mid_hdata", 32'(vif.hdata), 32'd5);
    chk("mid_vdata", 32'(vif.vdata), 32'd3);
    cyc(1);
    repeat (2 * HMAX) cyc(0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Upstream stage of the background painter and the other pixel painters.
- Generates the raster scan coordinates (hdata, vdata) that painters consume combinationally.
- Generates the sync and data-enable strobes for the VGA DAC, delayed to match the painter/mux pipeline.
- Also provides frame/line pulses and a frame counter for game-logic timing (e.g. tick per N frames).

Parameters:
- VGA_WIDTH, 12, width of hdata/vdata counters.
- HSIZE, 800, visible pixels per line.
- HFP, 856, hdata value where hsync pulse starts.
- HSP, 976, hdata value where hsync pulse ends (exclusive).
- HMAX, 1040, total pixels per line; hdata range 0..HMAX-1.
- VSIZE, 600, visible lines per frame.
- VFP, 637, vdata value where vsync pulse starts.
- VSP, 643, vdata value where vsync pulse ends (exclusive).
- VMAX, 666, total lines per frame; vdata range 0..VMAX-1.
- HSPP, 1, hsync active polarity.
- VSPP, 1, vsync active polarity.
- PIPE_DELAY, 1, extra cycles (0..4) applied to hsync/vsync/data_enable to align with downstream pixel pipeline.
- FCNT_WIDTH, 16, frame counter width.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- hdata  out  VGA_WIDTH  current horizontal pixel index, registered.
- vdata  out  VGA_WIDTH  current line index, registered.
- hsync  out  1  horizontal sync, delayed by PIPE_DELAY.
- vsync  out  1  vertical sync, delayed by PIPE_DELAY.
- data_enable  out  1  visible-region strobe, delayed by PIPE_DELAY.
- line_start  out  1  one-cycle pulse when hdata==0 (undelayed).
- frame_start  out  1  one-cycle pulse when hdata==0 && vdata==0 (undelayed).
- frame_count  out  FCNT_WIDTH  number of completed frames since reset.

Behaviour:
- Reset (synchronous, active-high; sampled on rising clk): hdata=0, vdata=0, frame_count=0, line_start=0, frame_start=0, hsync=!HSPP, vsync=!VSPP, data_enable=0. All delay-line stages flush to these inactive values.
- After reset deasserts, the first cycle holds hdata=0, vdata=0. line_start and frame_start are 1 in that cycle.
- hdata increments by 1 every cycle. At hdata==HMAX-1 it wraps to 0 on the next cycle.
- vdata increments only when hdata wraps. At vdata==VMAX-1 with hdata==HMAX-1, both wrap to 0.
- When that double wrap occurs, frame_count increments, wrapping modulo 2^FCNT_WIDTH with no saturation.
- Undelayed strobes are computed from the current registered counters:
  - hs_raw = HSPP when HFP<=hdata<HSP, else !HSPP.
  - vs_raw = VSPP when VFP<=vdata<VSP, else !VSPP.
  - de_raw = (hdata<HSIZE) && (vdata<VSIZE).
- hsync/vsync/data_enable equal hs_raw/vs_raw/de_raw delayed by exactly PIPE_DELAY clock cycles via a shift register. PIPE_DELAY=0 means a combinational pass-through of the raw values.
- line_start = (hdata==0); frame_start = (hdata==0 && vdata==0). Both are asserted in the same cycle as the matching counter value, with zero delay.
- Latency: painter output for coordinate (h,v) is valid in the cycle hdata==h. Sync/DE for that pixel appear PIPE_DELAY cycles later.
- Boundaries:
  - hdata==HSIZE-1 is the last DE-raw cycle of a line.
  - vdata==VSIZE-1 is the last visible line.
  - Sync is active on the closed-open intervals only: hdata==HSP is inactive.
- Reset mid-frame: counters return to 0 on the next edge, delay line clears, and no spurious sync/DE pulse is emitted.
- Elaboration-time checks (assertions): HSIZE<HFP<HSP<=HMAX, VSIZE<VFP<VSP<=VMAX, HMAX and VMAX fit in VGA_WIDTH, PIPE_DELAY<=4.

Test Plan:
- Reset for 3 cycles, release -> hdata=0, vdata=0, frame_start=1 and line_start=1 in the first cycle. Next cycle hdata=1, pulses 0. hsync=0, vsync=0, data_enable=0 during reset.
- Run 1040 cycles -> hdata wraps 1039->0, vdata 0->1, line_start pulses at cycle 1040; frame_start stays 0.
- PIPE_DELAY=1: hs_raw goes active at hdata=856 -> hsync high from the cycle hdata=857 through hdata=976 inclusive (120 cycles). data_enable falls in the cycle hdata=801.
- Run one full frame (1040*666=692640 cycles) -> frame_count 0->1 at the vdata/hdata double wrap, frame_start re-pulses. vsync high for exactly 6 lines (vdata 637..642 raw) = 6240 cycles.
- Assert reset at hdata=500, vdata=300 for 1 cycle -> next cycle hdata=0, vdata=0, frame_count=0, and hsync/vsync/data_enable low for PIPE_DELAY cycles with no glitch.
- FCNT_WIDTH=2, run 4 frames -> frame_count sequence 0,1,2,3,0.
